// File: rtl/fpcif_pkg.sv
// Shared types and constants for arbiters in front of the int-to-float conversion unit.
// Result flag bits: invalid, divzero, overflow, underflow, inexact (MSB to LSB).
package fpcif_pkg;

  localparam int FP_W   = 32;
  localparam int FLAG_W = 5;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/fpcif_arbiter_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr, searching circularly.
// Purely combinational; vld is low when no request is asserted.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    vld
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpcif_arbiter.sv
// Shares one multi-cycle fpcif converter among NREQ requesters with round-robin grant.
// Latency: req sampled -> ack two cycles later plus one per unit stall; unit stall holds RUN.
module fpcif_arbiter
  import fpcif_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [FP_W*NREQ-1:0] x,
  output logic [NREQ-1:0]      ack,
  output logic [FP_W-1:0]      z,
  output logic [FLAG_W-1:0]    flags,
  output logic                 busy,
  output logic [CNTW-1:0]      ops,
  output logic                 u_run,
  output logic [FP_W-1:0]      u_x,
  input  logic                 u_stall,
  input  logic [FP_W-1:0]      u_z,
  input  logic [FLAG_W-1:0]    u_flags
);

  localparam int IW = $clog2(NREQ);

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, gnt_q;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;
  logic [FP_W-1:0]     opnd_q, x_sel;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [FP_W-1:0]     z_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [CNTW-1:0]     ops_q;
  logic                busy_q;
  logic                grant_ld, done;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) x_sel = x[FP_W*i +: FP_W];
    end
  end

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IW'(i)) ack_d[i] = 1'b1;
    end
  end

  // req is only looked at in IDLE, so the cycle spent in ACK hides a winner's stale request.
  always_comb begin
    state_d  = state_q;
    grant_ld = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = RUN;
          grant_ld = 1'b1;
        end
      end
      RUN: begin
        if (!u_stall) begin
          state_d = ACK;
          done    = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      opnd_q  <= '0;
      ack_q   <= '0;
      z_q     <= '0;
      flags_q <= '0;
      ops_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ack_q   <= done ? ack_d : '0;
      if (grant_ld) begin
        gnt_q  <= pick_idx;
        opnd_q <= x_sel;
      end
      if (done) begin
        z_q     <= u_z;
        flags_q <= u_flags;
        ops_q   <= ops_q + CNTW'(1);
        ptr_q   <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
      end
    end
  end

  assign u_run = (state_q == RUN);
  assign u_x   = opnd_q;
  assign ack   = ack_q;
  assign z     = z_q;
  assign flags = flags_q;
  assign ops   = ops_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fpcif_arbiter.sv
// Directed bench for fpcif_arbiter with a converter model and a cycle-level scoreboard.
module tb_fpcif_arbiter;

  localparam int NREQ = 2;
  localparam int CNTW = 2;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [32*NREQ-1:0] x;
  logic [NREQ-1:0]  ack;
  logic [31:0]      z;
  logic [4:0]       flags;
  logic             busy;
  logic [CNTW-1:0]  ops;
  logic             u_run;
  logic [31:0]      u_x;
  logic             u_stall;
  logic [31:0]      u_z;
  logic [4:0]       u_flags;

  fpcif_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .x       (x),
    .ack     (ack),
    .z       (z),
    .flags   (flags),
    .busy    (busy),
    .ops     (ops),
    .u_run   (u_run),
    .u_x     (u_x),
    .u_stall (u_stall),
    .u_z     (u_z),
    .u_flags (u_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_stalls = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Reference int-to-float results for the operands used here: {z, flags}.
  function automatic logic [36:0] conv(input logic [31:0] v);
    case (v)
      32'h00000001: conv = {32'h3F800000, 5'b00000};
      32'h7FFFFFFF: conv = {32'h4F000000, 5'b00001};
      32'h00000002: conv = {32'h40000000, 5'b00000};
      32'h00000003: conv = {32'h40400000, 5'b00000};
      32'h00000004: conv = {32'h40800000, 5'b00000};
      32'h00000005: conv = {32'h40A00000, 5'b00000};
      32'h00000006: conv = {32'h40C00000, 5'b00000};
      default:      conv = {v ^ 32'hA5A5A5A5, 5'b10000};
    endcase
  endfunction

  // Converter model: stalls cfg_stalls run cycles, then presents the result.
  int run_cnt = 0;
  initial begin
    logic [36:0] r;
    u_stall = 1'b1;
    u_z     = '0;
    u_flags = '0;
    forever begin
      @(negedge clk);
      if (u_run) begin
        u_stall = (run_cnt < cfg_stalls);
        run_cnt++;
      end else begin
        run_cnt = 0;
        u_stall = 1'b1;
      end
      r       = conv(u_x);
      u_z     = u_stall ? 32'hDEADBEEF : r[36:5];
      u_flags = u_stall ? 5'b11111 : r[4:0];
    end
  end

  // Scoreboard: one job at a time, described by the cycles it occupies.
  int          cyc = 0;
  bit          m_job = 0;
  int          m_who = 0;
  logic [31:0] m_x = '0;
  int          m_start = 0, m_end = 0, m_ack = 0, m_free = 0;
  int          m_ptr = 0;
  int          m_ops = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_job  = 0;
        m_ptr  = 0;
        m_ops  = 0;
        m_free = 0;
      end else begin
        if (m_job && cyc == m_end) m_ops++;
        if (m_job && cyc == m_ack) m_job = 0;
        if (!m_job && cyc >= m_free) begin
          for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (!m_job && req[i]) begin
              m_job   = 1;
              m_who   = i;
              m_x     = x[32*i +: 32];
              m_start = cyc + 1;
              m_end   = cyc + 1 + cfg_stalls;
              m_ack   = m_end + 1;
              m_free  = m_ack + 1;
              m_ptr   = (i + 1) % NREQ;
            end
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit          er;
        bit          ea;
        logic [NREQ-1:0] eack;
        logic [36:0] r;
        er   = m_job && cyc >= m_start && cyc <= m_end;
        ea   = m_job && cyc == m_ack;
        eack = ea ? NREQ'(1 << m_who) : '0;
        chk("u_run", u_run, er);
        if (er) chk("u_x", u_x, m_x);
        chk("busy", busy, m_job && cyc >= m_start && cyc <= m_ack);
        chk("ack", ack, eack);
        if (ea) begin
          r = conv(m_x);
          chk("z", z, r[36:5]);
          chk("flags", flags, r[4:0]);
        end
        chk("ops", ops, m_ops % (1 << CNTW));
      end
    end
  end

  logic [NREQ-1:0] ack_log [8];
  int              ops_log [8];
  int              cyc_log [8];

  task automatic wait_acks(input int n, input bit rearm);
    int got;
    logic [NREQ-1:0] pend;
    got  = 0;
    pend = '0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (pend != '0) begin
        req  = req | pend;
        pend = '0;
      end
      if (ack != '0) begin
        ack_log[got] = ack;
        ops_log[got] = int'(ops);
        cyc_log[got] = cyc;
        req = req & ~ack;
        if (rearm) pend = ack;
        got++;
      end
    end
    chk("ack_count", got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc;
    int spur;
    rst_n = 1'b0;
    req   = '0;
    x     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_z", z, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops, 0);
    chk("rst_u_run", u_run, 0);
    chk("rst_u_x", u_x, 0);
    #2 rst_n = 1'b1;

    // single request, no stall
    @(negedge clk);
    cfg_stalls = 0;
    x[31:0] = 32'h00000001;
    req = 2'b01;
    rc = cyc;
    wait_acks(1, 0);
    chk("single_ack", ack_log[0], 2'b01);
    chk("single_lat", cyc_log[0] - rc, 2);
    chk("single_z", z, 32'h3F800000);
    chk("single_flags", flags, 5'b00000);
    chk("single_ops", ops_log[0], 1);

    // stalled conversion; operand changes underneath while running
    @(negedge clk);
    cfg_stalls = 3;
    x[63:32] = 32'h7FFFFFFF;
    req = 2'b10;
    rc = cyc;
    repeat (2) @(negedge clk);
    x[63:32] = 32'h12345678;
    wait_acks(1, 0);
    chk("stall_ack", ack_log[0], 2'b10);
    chk("stall_lat", cyc_log[0] - rc, 5);
    chk("stall_z", z, 32'h4F000000);
    chk("stall_flags", flags, 5'b00001);
    chk("stall_ops", ops_log[0], 2);

    // requester 0 drops mid-run, requester 1 arrives
    @(negedge clk);
    cfg_stalls = 2;
    x[31:0] = 32'h00000004;
    req = 2'b01;
    repeat (2) @(negedge clk);
    x[63:32] = 32'h00000005;
    req = 2'b10;
    wait_acks(2, 0);
    chk("drop_ack0", ack_log[0], 2'b01);
    chk("drop_ack1", ack_log[1], 2'b10);
    chk("drop_ops_wrap", ops_log[1], 0);

    // reset in the middle of a long conversion
    @(negedge clk);
    cfg_stalls = 6;
    x[31:0] = 32'h00000006;
    req = 2'b01;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_u_run", u_run, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_ops", ops, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) spur++;
    end
    chk("midrst_no_ack", spur, 0);

    // both requesters held: strict alternation and counter wrap
    @(negedge clk);
    cfg_stalls = 1;
    x = {32'h00000003, 32'h00000002};
    req = 2'b11;
    wait_acks(5, 1);
    chk("rr_ack0", ack_log[0], 2'b01);
    chk("rr_ack1", ack_log[1], 2'b10);
    chk("rr_ack2", ack_log[2], 2'b01);
    chk("rr_ack3", ack_log[3], 2'b10);
    chk("rr_ack4", ack_log[4], 2'b01);
    chk("wrap_ops0", ops_log[0], 1);
    chk("wrap_ops1", ops_log[1], 2);
    chk("wrap_ops2", ops_log[2], 3);
    chk("wrap_ops3", ops_log[3], 0);
    chk("wrap_ops4", ops_log[4], 1);
    req = '0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpcif_arbiter.md
Name: fpcif_arbiter

Overview:
- Shares one multi-cycle int-to-float conversion unit (fpcif, run/stall handshake) between NREQ requesters.
- Round-robin grant; latches the granted operand and sequences run/stall to completion.
- Returns z/flags with a one-cycle ack pulse to the winner.
- Sits between the requesting pipeline stages and the single fpcif instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held high until own ack is seen.
- x  in  32*NREQ  requester operands; slice i = x[32*i+31:32*i]; valid while req[i]=1.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- z  out  32  result; valid only in the cycle ack!=0.
- flags  out  5  exception flags; valid only in the cycle ack!=0.
- busy  out  1  high in RUN and ACK states.
- ops  out  CNTW  count of completed operations; wraps.
- u_run  out  1  to fpcif run.
- u_x  out  32  to fpcif x; driven from operand register.
- u_stall  in  1  from fpcif stall.
- u_z  in  32  from fpcif z.
- u_flags  in  5  from fpcif flags.

Behaviour:
- Reset (async, immediate): state=IDLE, ack=0, z=0, flags=0, busy=0, ops=0, u_run=0, u_x=0, priority pointer=0.
- Reset mid-RUN aborts the conversion; u_run drops combinationally with reset; no ack is issued.
- Unit protocol:
  - u_run=1 with u_x stable marks an active conversion.
  - At each rising edge with u_run=1: u_stall=1 means keep running.
  - u_stall=0 means u_z/u_flags are valid and are sampled at that edge.
- States:
  - IDLE: if any req, grant the first requester at or after the pointer (circular search); latch x slice into the operand register and the grant index; go to RUN. If no req, stay.
  - RUN: u_run=1, u_x=operand register. At an edge with u_stall=0, register u_z/u_flags into z/flags, set ack[grant]=1, increment ops, set pointer=grant+1 mod NREQ; go to ACK. Otherwise stay.
  - ACK: ack pulse visible this cycle only; u_run=0; go to IDLE; ack clears at the next edge.
- Requester rule: deassert req in the cycle after ack. IDLE does not re-grant the acked requester's stale req because ACK→IDLE consumes one cycle in which req has dropped.
- Latency: with zero-stall unit, req sampled at edge E0 → RUN in cycle 1, result sampled at E1 → ack high in cycle 2. Each extra stall cycle adds 1. Minimum issue interval is 3 cycles.
- Simultaneous requests: strict round-robin. A requester that just won has lowest priority next.
- req dropping while granted is ignored; the operation completes and acks anyway.
- ops wraps from 2^CNTW-1 to 0.
- Outputs ack, z, flags, ops, busy are registered. u_run and u_x decode from state/registers only, with no combinational path from req.

Decomposition:
- Shared package fpcif_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, ACK=2'd2)
  - FP_W=32, FLAG_W=5
  - flag bit indices: invalid, divzero, overflow, underflow, inexact.
- One natural sub-module: rr_pick, combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: grant index and any-valid.
  - Reused by future FP unit arbiters.

Test Plan:
- Reset: drive rst_n=0 mid-RUN with u_stall=1 → u_run=0 immediately, ack=0, ops=0; after release, IDLE with no spurious ack.
- Single request: req=2'b01, x0=32'h00000001, fpcif model returns 32'h3F800000 with flags=0 after 0 stalls → ack=2'b01 in cycle 2, z=32'h3F800000, ops=1.
- Stall: x1=32'h7FFFFFFF, model stalls 3 cycles and returns 32'h4F000000 with inexact flag=5'b00001 → ack=2'b10 exactly 5 cycles after request, u_x held constant during RUN.
- Fairness: req=2'b11 held continuously (re-raised after each ack) → acks alternate 01,10,01,10; ops=4 after four completions.
- Wrap: CNTW=2, five operations → ops sequence 1,2,3,0,1.
- Drop: requester 0 drops req during RUN → operation still completes, ack[0] pulses once, next IDLE grants only live requests.
